// File: rtl/block_mem_responder.sv
// Block memory responder for the cache refill/write port.
// 128-bit block reads, 32-bit word writes, fixed access latency.
module block_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          re,
  input  logic          we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]    offset,
  input  logic [31:0]   din,
  output logic [127:0]  dout,
  output logic          complete,
  output logic          busy
);

  if (LATENCY < 1 || LATENCY > 255) begin : g_lat_chk
    $error("block_mem_responder: LATENCY must be 1..255");
  end

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         off_q;
  logic [31:0]        din_q;
  logic               we_q;
  logic [127:0]       dout_d;
  logic               cmp_d, busy_d;
  logic               lat_en, mem_wr;
  logic [127:0]       merged;

  logic [127:0] mem [2**ADDR_W];

  // next-state, response data and merged write block
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout;
    cmp_d   = complete;
    busy_d  = busy;
    lat_en  = 1'b0;
    mem_wr  = 1'b0;
    merged  = mem[addr_q];
    if (we_q) merged[{off_q, 5'b0} +: 32] = din_q;
    unique case (state_q)
      IDLE: begin
        if (re || we) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
          busy_d  = 1'b1;
          lat_en  = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          mem_wr  = we_q;
          dout_d  = merged;
          cmp_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        if (!re && !we) begin
          cmp_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, counter and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      dout     <= '0;
      complete <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout     <= dout_d;
      complete <= cmp_d;
      busy     <= busy_d;
    end
  end

  // request capture; only these copies are used while busy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      off_q  <= '0;
      din_q  <= '0;
      we_q   <= 1'b0;
    end else if (lat_en) begin
      addr_q <= addr;
      off_q  <= offset;
      din_q  <= din;
      we_q   <= we;
    end
  end

  // block array, never cleared
  always_ff @(posedge clk) begin
    if (mem_wr) mem[addr_q] <= merged;
  end

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed self-checking bench for block_mem_responder.
// Three builds: LATENCY 4, 1 and 255.
module tb_block_mem_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   addr;
  logic [1:0]   offset;
  logic [31:0]  din;

  logic         re4, we4, cmp4, busy4;
  logic [127:0] dout4;
  logic         re1, we1, cmp1, busy1;
  logic [127:0] dout1;
  logic         re255, we255, cmp255, busy255;
  logic [127:0] dout255;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  block_mem_responder #(.ADDR_W(8), .LATENCY(4)) u4 (
    .clk(clk), .rst(rst), .re(re4), .we(we4), .addr(addr),
    .offset(offset), .din(din), .dout(dout4),
    .complete(cmp4), .busy(busy4)
  );

  block_mem_responder #(.ADDR_W(8), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .re(re1), .we(we1), .addr(addr),
    .offset(offset), .din(din), .dout(dout1),
    .complete(cmp1), .busy(busy1)
  );

  block_mem_responder #(.ADDR_W(8), .LATENCY(255)) u255 (
    .clk(clk), .rst(rst), .re(re255), .we(we255), .addr(addr),
    .offset(offset), .din(din), .dout(dout255),
    .complete(cmp255), .busy(busy255)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic acc4(input logic r, input logic w, input logic [7:0] a,
                      input logic [1:0] o, input logic [31:0] d,
                      output int edges);
    @(negedge clk);
    re4 = r; we4 = w; addr = a; offset = o; din = d;
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!cmp4 && edges < 20);
    @(negedge clk);
    re4 = 1'b0; we4 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pre(input logic [7:0] a, input logic [31:0] base);
    int e;
    for (int i = 0; i < 4; i++) acc4(1'b0, 1'b1, a, 2'(i), base + i, e);
  endtask

  initial begin
    rst = 1'b0;
    re4 = 0; we4 = 0; re1 = 0; we1 = 0; re255 = 0; we255 = 0;
    addr = '0; offset = '0; din = '0;
    @(posedge clk); #1;
    chk("rst_dout", dout4, 128'h0);
    chk("rst_cmp", {127'h0, cmp4}, 128'h0);
    chk("rst_busy", {127'h0, busy4}, 128'h0);
    @(negedge clk); rst = 1'b1;

    pre(8'h05, 32'h05050000);
    pre(8'h12, 32'h12120000);
    pre(8'h07, 32'h07070000);
    pre(8'h08, 32'h08080000);
    for (int i = 0; i < 4; i++) acc4(1'b0, 1'b1, 8'h30, 2'(i), 32'hAAAAAAAA, n);

    acc4(1'b0, 1'b1, 8'h12, 2'd2, 32'hDEADBEEF, n);
    chk("wr_lat", 128'(n), 128'd5);
    chk("wr_dout", dout4, 128'h12120003_DEADBEEF_12120001_12120000);
    acc4(1'b1, 1'b0, 8'h12, 2'd0, 32'h0, n);
    chk("rd_12", dout4, 128'h12120003_DEADBEEF_12120001_12120000);
    chk("rd_lat", 128'(n), 128'd5);

    acc4(1'b1, 1'b1, 8'h30, 2'd0, 32'h1, n);
    chk("rw_lat", 128'(n), 128'd5);
    chk("rw_dout", dout4, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000001);
    acc4(1'b1, 1'b0, 8'h30, 2'd0, 32'h0, n);
    chk("rw_array", dout4, 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_00000001);

    @(negedge clk);
    we4 = 1'b1; addr = 8'h07; offset = 2'd1; din = 32'h11112222;
    @(posedge clk); #1;
    chk("chg_busy", {127'h0, busy4}, 128'h1);
    @(negedge clk);
    addr = 8'h08; din = 32'h99999999; offset = 2'd3;
    n = 1;
    while (!cmp4 && n < 20) begin @(posedge clk); #1; n++; end
    chk("chg_lat", 128'(n), 128'd5);
    chk("chg_dout", dout4, 128'h07070003_07070002_11112222_07070000);
    @(negedge clk); we4 = 1'b0;
    @(posedge clk); #1;
    acc4(1'b1, 1'b0, 8'h08, 2'd0, 32'h0, n);
    chk("chg_blk8", dout4, 128'h08080003_08080002_08080001_08080000);
    acc4(1'b1, 1'b0, 8'h07, 2'd0, 32'h0, n);
    chk("chg_blk7", dout4, 128'h07070003_07070002_11112222_07070000);

    @(negedge clk);
    re4 = 1'b1; addr = 8'h05;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!cmp4 && n < 20);
    chk("hold_dout", dout4, 128'h05050003_05050002_05050001_05050000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_cmp", {126'h0, cmp4, busy4}, 128'h2);
    end
    @(negedge clk); re4 = 1'b0;
    @(posedge clk); #1;
    chk("drop_cmp", {127'h0, cmp4}, 128'h0);

    @(negedge clk);
    we4 = 1'b1; addr = 8'h05; offset = 2'd0; din = 32'h00000BAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    chk("mid_rst_dout", dout4, 128'h0);
    chk("mid_rst_flags", {126'h0, cmp4, busy4}, 128'h0);
    @(negedge clk); we4 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    acc4(1'b1, 1'b0, 8'h05, 2'd0, 32'h0, n);
    chk("rst_keep5", dout4, 128'h05050003_05050002_05050001_05050000);

    @(negedge clk);
    re1 = 1'b1; addr = 8'h00;
    @(posedge clk); #1;
    chk("l1_e1", {126'h0, cmp1, busy1}, 128'h1);
    @(posedge clk); #1;
    chk("l1_e2", {126'h0, cmp1, busy1}, 128'h2);
    @(negedge clk); re1 = 1'b0;

    @(negedge clk);
    re255 = 1'b1; addr = 8'h00;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!cmp255 && n < 300);
    chk("l255_lat", 128'(n), 128'd256);
    chk("l255_busy", {127'h0, busy255}, 128'h0);
    @(negedge clk); re255 = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
